// File: rtl/stepper_seq_gen.sv
// rtl/stepper_seq_gen.sv - parametrised stepper phase sequencer with rate divider and position counter
// Half/full/wave stepping over 2*PHASES half-step indices; registered coil drive and tick.
module stepper_seq_gen #(
    parameter int PHASES = 4,
    parameter int DIV_W  = 16,
    parameter int POS_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en_i,
    input  logic                    dir_i,
    input  logic [1:0]              mode_i,
    input  logic [DIV_W-1:0]        div_i,
    input  logic                    step_req_i,
    input  logic                    release_i,
    output logic [PHASES-1:0]       coils_o,
    output logic                    step_tick_o,
    output logic signed [POS_W-1:0] position_o
);

    localparam int NIDX  = 2 * PHASES;
    localparam int IDX_W = $clog2(NIDX);
    localparam logic [IDX_W:0]    NIDX_L  = (IDX_W+1)'(NIDX);
    localparam logic [PHASES-1:0] COIL0_B = {1'b1, {(PHASES-1){1'b0}}};

    localparam logic [1:0] MODE_FULL = 2'b01;
    localparam logic [1:0] MODE_WAVE = 2'b10;

    // Coil c drives bit PHASES-1-c, so shifting the MSB right by c selects coil c.
    function automatic logic [PHASES-1:0] decode(input logic [IDX_W-1:0] k);
        int lo;
        int hi;
        lo = int'(k) / 2;
        hi = (lo + 1) % PHASES;
        decode = COIL0_B >> lo;
        if (k[0]) begin
            decode = decode | (COIL0_B >> hi);
        end
    endfunction

    logic [DIV_W-1:0]  cnt_q,   cnt_d;
    logic [IDX_W-1:0]  idx_q,   idx_d;
    logic [POS_W-1:0]  pos_q,   pos_d;
    logic [PHASES-1:0] coils_q, coils_d;
    logic              tick_q,  tick_d;

    logic              step;
    logic [1:0]        delta;
    logic [IDX_W:0]    idx_ext;
    logic [IDX_W:0]    delta_ext;
    logic [IDX_W:0]    sum;

    always_comb begin
        step      = 1'b0;
        delta     = 2'd1;
        cnt_d     = '0;
        idx_d     = idx_q;
        pos_d     = pos_q;
        tick_d    = 1'b0;
        sum       = '0;
        idx_ext   = {1'b0, idx_q};

        // Prescaler: a lowered div below the running count fires on the next edge.
        if (en_i) begin
            step  = (cnt_q >= div_i);
            cnt_d = step ? '0 : cnt_q + 1'b1;
        end else begin
            step  = step_req_i;
        end

        // Full realigns onto two-coil (odd) indices, wave onto one-coil (even) indices.
        if (mode_i == MODE_FULL) begin
            delta = idx_q[0] ? 2'd2 : 2'd1;
        end else if (mode_i == MODE_WAVE) begin
            delta = idx_q[0] ? 2'd1 : 2'd2;
        end
        delta_ext = (IDX_W+1)'(delta);

        if (idx_ext >= NIDX_L) begin
            idx_d = '0;
        end else if (step) begin
            tick_d = 1'b1;
            if (dir_i) begin
                sum   = idx_ext + NIDX_L - delta_ext;
                pos_d = pos_q - POS_W'(delta);
            end else begin
                sum   = idx_ext + delta_ext;
                pos_d = pos_q + POS_W'(delta);
            end
            if (sum >= NIDX_L) begin
                sum = sum - NIDX_L;
            end
            idx_d = sum[IDX_W-1:0];
        end

        // Coils follow idx_d every cycle; idx only moves on a step, so no glitches.
        coils_d = release_i ? '0 : decode(idx_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            pos_q   <= '0;
            coils_q <= COIL0_B;
            tick_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            pos_q   <= pos_d;
            coils_q <= coils_d;
            tick_q  <= tick_d;
        end
    end

    assign coils_o     = coils_q;
    assign step_tick_o = tick_q;
    assign position_o  = pos_q;

endmodule

// File: tb/tb_stepper_seq_gen.sv
// tb/tb_stepper_seq_gen.sv - directed and random checks of stepper_seq_gen against a table model
module tb_stepper_seq_gen;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en_i, dir_i, step_req_i, release_i;
    logic [1:0]        mode_i;
    logic [15:0]       div_i;
    logic [3:0]        coils_o;
    logic              step_tick_o;
    logic signed [15:0] position_o;

    int n_cmp = 0;
    int n_err = 0;

    int m_idx, m_pos, m_cnt;
    bit m_tick;
    logic [3:0] tab [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                            4'b0010, 4'b0011, 4'b0001, 4'b1001};

    always #5 clk = ~clk;

    stepper_seq_gen #(.PHASES(4), .DIV_W(16), .POS_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en_i        (en_i),
        .dir_i       (dir_i),
        .mode_i      (mode_i),
        .div_i       (div_i),
        .step_req_i  (step_req_i),
        .release_i   (release_i),
        .coils_o     (coils_o),
        .step_tick_o (step_tick_o),
        .position_o  (position_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] m_coils();
        return release_i ? 4'b0000 : tab[m_idx];
    endfunction

    task automatic model_reset();
        m_idx = 0; m_pos = 0; m_cnt = 0; m_tick = 0;
    endtask

    task automatic model_edge();
        bit s;
        int d;
        if (en_i) begin
            s = (m_cnt >= int'(div_i));
            m_cnt = s ? 0 : m_cnt + 1;
        end else begin
            s = step_req_i;
            m_cnt = 0;
        end
        m_tick = s;
        if (s) begin
            d = 1;
            if (mode_i == 2'b01 && (m_idx % 2) == 1) d = 2;
            if (mode_i == 2'b10 && (m_idx % 2) == 0) d = 2;
            m_idx = dir_i ? (m_idx - d + 8) % 8 : (m_idx + d) % 8;
            m_pos = dir_i ? m_pos - d : m_pos + d;
        end
    endtask

    task automatic cyc(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check({tag, ".coils"}, 32'(coils_o), 32'(m_coils()));
        check({tag, ".tick"}, 32'(step_tick_o), 32'(m_tick));
        check({tag, ".pos"}, 32'(16'(position_o)), 32'(16'(m_pos)));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst.coils", 32'(coils_o), 32'(4'b1000));
        check("rst.tick", 32'(step_tick_o), 32'd0);
        check("rst.pos", 32'(16'(position_o)), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_in(input logic e, input logic dr, input logic [1:0] md,
                          input logic [15:0] dv, input logic sr, input logic rl);
        en_i = e; dir_i = dr; mode_i = md; div_i = dv; step_req_i = sr; release_i = rl;
    endtask

    logic [3:0] exp1 [8] = '{4'b1100, 4'b0100, 4'b0110, 4'b0010,
                             4'b0011, 4'b0001, 4'b1001, 4'b1000};
    logic [3:0] exp2 [3] = '{4'b1001, 4'b0001, 4'b0011};

    initial begin
        int ticks;
        bool_found: begin end
        rst_n = 1'b1;
        set_in(0, 0, 2'b00, 16'd0, 0, 0);

        // Half-step forward, one step per cycle.
        do_reset();
        set_in(1, 0, 2'b00, 16'd0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            cyc("t1");
            check("t1.seq", 32'(coils_o), 32'(exp1[i]));
            check("t1.seqpos", 32'(16'(position_o)), 32'(i + 1));
        end

        // Half-step reverse wraps 0 -> 7.
        do_reset();
        set_in(1, 1, 2'b00, 16'd0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc("t2");
            check("t2.seq", 32'(coils_o), 32'(exp2[i]));
            check("t2.seqpos", 32'(16'(position_o)), 32'(16'(-(i + 1))));
        end

        // Full then wave with realignment.
        do_reset();
        set_in(1, 0, 2'b01, 16'd0, 0, 0);
        for (int i = 0; i < 5; i++) cyc("t3f");
        check("t3.fullpos", 32'(16'(position_o)), 32'd9);
        mode_i = 2'b10;
        cyc("t3w");
        check("t3.wave0", 32'(coils_o), 32'(4'b0100));
        for (int i = 0; i < 2; i++) cyc("t3w");
        check("t3.wave2", 32'(coils_o), 32'(4'b0001));

        // Divider period and a lowered div below the running count.
        do_reset();
        set_in(1, 0, 2'b00, 16'd3, 0, 0);
        ticks = 0;
        for (int i = 0; i < 12; i++) begin
            cyc("t4a");
            ticks += int'(step_tick_o);
        end
        check("t4.ticks12", 32'(ticks), 32'd3);
        ticks = 0;
        for (int i = 0; i < 8 && m_cnt != 2; i++) cyc("t4w");
        check("t4.cnt2found", 32'(m_cnt), 32'd2);
        div_i = 16'd1;
        cyc("t4b");
        check("t4.ticknext", 32'(step_tick_o), 32'd1);
        for (int i = 0; i < 6; i++) begin
            cyc("t4c");
            ticks += int'(step_tick_o);
        end
        check("t4.ticks6", 32'(ticks), 32'd3);

        // Single-step requests, then step_req ignored while free-running.
        do_reset();
        set_in(0, 0, 2'b00, 16'd0, 0, 0);
        for (int p = 0; p < 3; p++) begin
            step_req_i = 1'b1; cyc("t5p");
            step_req_i = 1'b0; cyc("t5i"); cyc("t5i");
        end
        check("t5.pos3", 32'(16'(position_o)), 32'd3);
        set_in(1, 0, 2'b00, 16'd5, 1, 0);
        ticks = 0;
        for (int i = 0; i < 18; i++) begin
            cyc("t5r");
            ticks += int'(step_tick_o);
        end
        check("t5.ticks18", 32'(ticks), 32'd3);

        // Release while stepping, re-energise, then async reset mid-run.
        do_reset();
        set_in(0, 0, 2'b00, 16'd0, 0, 1);
        cyc("t6h");
        for (int p = 0; p < 3; p++) begin
            step_req_i = 1'b1; cyc("t6p");
            step_req_i = 1'b0; cyc("t6i");
        end
        check("t6.relcoils", 32'(coils_o), 32'd0);
        check("t6.relpos", 32'(16'(position_o)), 32'd3);
        release_i = 1'b0;
        cyc("t6r");
        check("t6.decode3", 32'(coils_o), 32'(4'b0110));
        set_in(1, 0, 2'b00, 16'd0, 0, 0);
        cyc("t6s"); cyc("t6s");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("t6.async.coils", 32'(coils_o), 32'(4'b1000));
        check("t6.async.pos", 32'(16'(position_o)), 32'd0);
        check("t6.async.tick", 32'(step_tick_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                set_in(1'($urandom), 1'($urandom), 2'($urandom), 16'($urandom_range(0, 4)),
                       1'($urandom), ($urandom_range(0, 5) == 0));
            end else begin
                step_req_i = 1'($urandom);
                if ($urandom_range(0, 15) == 0) dir_i = ~dir_i;
                if ($urandom_range(0, 15) == 0) mode_i = 2'($urandom);
            end
            cyc("rnd");
            if ($urandom_range(0, 199) == 0) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
